// File: rtl/hazard_unit.sv
// Pipeline interlock and forwarding controller for the five-stage MIPS core.
// Tracks X/M/W write footprints; drives bypass selects, load-use stall and flush.
module hazard_unit #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            d_insn,
    input  logic [13:0]            d_controls,
    input  logic                   d_valid,
    input  logic                   branch_taken,
    output logic                   MX_abypass,
    output logic                   MX_bbypass,
    output logic                   WX_abypass,
    output logic                   WX_bbypass,
    output logic                   WM_bypass,
    output logic                   stall,
    output logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int C_RDST   = 13;
    localparam int C_DMEN   = 12;
    localparam int C_RWE    = 11;
    localparam int C_ALUINB = 10;
    localparam int C_DMWE   = 9;
    localparam int C_JP     = 7;

    localparam logic [5:0] OP_JAL = 6'h03;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic       we;
        logic       is_load;
        logic       is_store;
        logic       uses_rs;
        logic       uses_rt;
    } stage_t;

    function automatic stage_t decode(
        input logic [31:0] insn,
        input logic [13:0] ctl,
        input logic        valid
    );
        stage_t     r;
        logic [5:0] op;
        op         = insn[31:26];
        r.valid    = valid;
        r.rs       = insn[25:21];
        r.rt       = insn[20:16];
        if (ctl[C_JP] && op == OP_JAL)
            r.dest = 5'd31;
        else if (ctl[C_RDST])
            r.dest = insn[15:11];
        else
            r.dest = insn[20:16];
        r.we       = ctl[C_RWE] && (r.dest != 5'd0);
        r.is_load  = ctl[C_RWE] && ctl[C_DMEN] && !ctl[C_DMWE];
        r.is_store = ctl[C_DMEN] && ctl[C_DMWE];
        r.uses_rs  = !(ctl[C_JP] && op != 6'd0);
        r.uses_rt  = !ctl[C_ALUINB] || ctl[C_DMWE];
        return r;
    endfunction

    stage_t d_rec;
    stage_t x_rec;
    stage_t m_rec;
    stage_t w_rec;

    logic mx_a_hit;
    logic mx_b_hit;
    logic wx_a_hit;
    logic wx_b_hit;
    logic ld_rs_hit;
    logic ld_rt_hit;
    logic unused_bits;

    always_comb begin
        d_rec = decode(d_insn, d_controls, d_valid);
    end

    // M never forwards a load: the load-use stall lets W serve it instead
    always_comb begin
        mx_a_hit = x_rec.valid && x_rec.uses_rs && m_rec.valid
                && m_rec.we && !m_rec.is_load
                && (m_rec.dest == x_rec.rs);
        mx_b_hit = x_rec.valid && x_rec.uses_rt && m_rec.valid
                && m_rec.we && !m_rec.is_load
                && (m_rec.dest == x_rec.rt);
        wx_a_hit = x_rec.valid && x_rec.uses_rs && w_rec.valid
                && w_rec.we && (w_rec.dest == x_rec.rs);
        wx_b_hit = x_rec.valid && x_rec.uses_rt && w_rec.valid
                && w_rec.we && (w_rec.dest == x_rec.rt);
    end

    assign MX_abypass = mx_a_hit;
    assign MX_bbypass = mx_b_hit;
    assign WX_abypass = wx_a_hit && !mx_a_hit;
    assign WX_bbypass = wx_b_hit && !mx_b_hit;

    assign WM_bypass = m_rec.valid && m_rec.is_store
                    && w_rec.valid && w_rec.we
                    && (w_rec.dest == m_rec.rt);

    always_comb begin
        ld_rs_hit = d_rec.uses_rs && (x_rec.dest == d_rec.rs);
        ld_rt_hit = d_rec.uses_rt && (x_rec.dest == d_rec.rt);
    end

    // A taken branch makes the D instruction wrong-path, so flush beats stall
    assign stall = d_valid && x_rec.valid && x_rec.is_load && x_rec.we
                && (ld_rs_hit || ld_rt_hit) && !branch_taken;
    assign flush = branch_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_rec       <= '0;
            m_rec       <= '0;
            w_rec       <= '0;
            stall_count <= '0;
        end else begin
            w_rec <= m_rec;
            m_rec <= x_rec;
            if (flush || stall)
                x_rec <= '0;
            else
                x_rec <= d_rec;
            if (stall && (stall_count != '1))
                stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

    assign unused_bits = ^{d_insn[10:0], d_controls[8], d_controls[6:0],
                           x_rec, m_rec, w_rec};

endmodule
